// File: rtl/intra16_mode_decision_if.sv
// ---------------------------------------------------------------------------
// intra16_mode_decision_if
//   Bundle of the macroblock request and result handshake for the Intra16x16
//   mode-decision block.
//
//   Request side (master -> slave):
//     start       single-cycle request
//     mb          256 luma pixels, row j / col k at index j*16+k
//     top, left   reconstructed neighbour row / column (16 pixels each)
//     top_avail   top neighbours valid
//     left_avail  left neighbours valid
//     out_ready   consumer accepts the result
//   Result side (slave -> master):
//     busy        block is not idle
//     out_valid   result valid
//     best_mode   0 = vertical, 1 = horizontal, 2 = DC
//     best_sad    cost of best_mode
//     sad_v/h/dc  raw SAD of each prediction
// ---------------------------------------------------------------------------
interface intra16_mode_decision_if;
  logic        start;
  logic [7:0]  mb   [255:0];
  logic [7:0]  top  [15:0];
  logic [7:0]  left [15:0];
  logic        top_avail;
  logic        left_avail;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  best_mode;
  logic [15:0] best_sad;
  logic [15:0] sad_v;
  logic [15:0] sad_h;
  logic [15:0] sad_dc;

  modport master (
    output start, mb, top, left, top_avail, left_avail, out_ready,
    input  busy, out_valid, best_mode, best_sad, sad_v, sad_h, sad_dc
  );

  modport slave (
    input  start, mb, top, left, top_avail, left_avail, out_ready,
    output busy, out_valid, best_mode, best_sad, sad_v, sad_h, sad_dc
  );
endinterface

// File: rtl/intra16_mode_decision.sv
// ---------------------------------------------------------------------------
// intra16_mode_decision
//   Scores the Intra16x16 vertical, horizontal and DC predictions of one
//   16x16 luma macroblock by SAD, one MB row per cycle, and reports the
//   cheapest mode through a valid/ready handshake.
//
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high reset
//     bus    intra16_mode_decision_if.slave (request + result handshake)
//
//   Timing: start accepted in cycle 0 -> out_valid first high in cycle 19
//   (IDLE, DCCALC, 16 x ACCUM, DECIDE, DONE).
//
//   Optional build macro INTRA16_MODE_BIAS_EN: when defined, MODE_BIAS is
//   added (saturating) to the vertical and horizontal costs before the
//   comparison and best_sad reports the biased cost. sad_v/sad_h/sad_dc are
//   always the unbiased values.
// ---------------------------------------------------------------------------
module intra16_mode_decision #(
  parameter int MB_SIZE   = 16,  // only 16 is supported
  parameter int MODE_BIAS = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  intra16_mode_decision_if.slave  bus
);

  localparam logic [3:0]  LAST_ROW = 4'(MB_SIZE - 1);
  localparam logic [15:0] SAD_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DCCALC,
    S_ACCUM,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t      r_state, w_next_state;

  logic [7:0]  r_top  [15:0];
  logic [7:0]  r_left [15:0];
  logic        r_top_avail, r_left_avail;
  logic [3:0]  r_row;
  logic [7:0]  r_dc_pred;
  logic [15:0] r_acc_v, r_acc_h, r_acc_dc;

  logic [1:0]  r_best_mode;
  logic [15:0] r_best_sad, r_sad_v, r_sad_h, r_sad_dc;

  logic [11:0] w_sum_t, w_sum_l;
  logic [7:0]  w_dc_pred;
  logic [11:0] w_row_v, w_row_h, w_row_dc;
  logic [15:0] w_raw_v, w_raw_h;
  logic [15:0] w_cost_v, w_cost_h, w_cost_dc;
  logic [1:0]  w_best_mode;
  logic [15:0] w_best_sad;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

`ifdef INTRA16_MODE_BIAS_EN
  localparam logic [15:0] BIAS = 16'(MODE_BIAS);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? SAD_MAX : s[15:0];
  endfunction
`else
  // MODE_BIAS has no effect in this build; the reduction only marks the
  // parameter as deliberately consumed.
  logic w_unused_bias;
  assign w_unused_bias = ^(16'(MODE_BIAS));
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start)        w_next_state = S_DCCALC;
      S_DCCALC:                       w_next_state = S_ACCUM;
      S_ACCUM:  if (r_row == LAST_ROW) w_next_state = S_DECIDE;
      S_DECIDE:                       w_next_state = S_DONE;
      S_DONE:   if (bus.out_ready)    w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // DC predictor from the latched neighbours
  // -------------------------------------------------------------------------
  always_comb begin
    logic [12:0] both;
    w_sum_t = '0;
    w_sum_l = '0;
    for (int k = 0; k < MB_SIZE; k++) begin
      w_sum_t = w_sum_t + 12'(r_top[k]);
      w_sum_l = w_sum_l + 12'(r_left[k]);
    end
    both = 13'(w_sum_t) + 13'(w_sum_l) + 13'd16;
    unique case ({r_top_avail, r_left_avail})
      2'b11:   w_dc_pred = both[12:5];
      2'b10:   w_dc_pred = 8'((w_sum_t + 12'd8) >> 4);
      2'b01:   w_dc_pred = 8'((w_sum_l + 12'd8) >> 4);
      default: w_dc_pred = 8'd128;
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-row SAD contributions for the current row r_row
  // -------------------------------------------------------------------------
  // NOTE: blocking '=' is correct inside always_comb, where each loop
  // iteration must see the partial sum of the previous one; clocked state
  // below uses '<=' only.
  always_comb begin
    logic [7:0] pix;
    w_row_v  = '0;
    w_row_h  = '0;
    w_row_dc = '0;
    for (int k = 0; k < MB_SIZE; k++) begin
      pix      = bus.mb[{r_row, 4'(k)}];
      w_row_v  = w_row_v  + 12'(abs_diff(pix, r_top[k]));
      w_row_h  = w_row_h  + 12'(abs_diff(pix, r_left[r_row]));
      w_row_dc = w_row_dc + 12'(abs_diff(pix, r_dc_pred));
    end
  end

  // -------------------------------------------------------------------------
  // Decision: unavailable directions are priced out, ties go to the lower
  // mode number because each comparison uses <=.
  // -------------------------------------------------------------------------
  always_comb begin
    w_raw_v = r_top_avail  ? r_acc_v : SAD_MAX;
    w_raw_h = r_left_avail ? r_acc_h : SAD_MAX;
`ifdef INTRA16_MODE_BIAS_EN
    w_cost_v = r_top_avail  ? sat_add(r_acc_v, BIAS) : SAD_MAX;
    w_cost_h = r_left_avail ? sat_add(r_acc_h, BIAS) : SAD_MAX;
`else
    w_cost_v = w_raw_v;
    w_cost_h = w_raw_h;
`endif
    w_cost_dc = r_acc_dc;

    if (w_cost_v <= w_cost_h && w_cost_v <= w_cost_dc) begin
      w_best_mode = 2'd0;
      w_best_sad  = w_cost_v;
    end else if (w_cost_h <= w_cost_dc) begin
      w_best_mode = 2'd1;
      w_best_sad  = w_cost_h;
    end else begin
      w_best_mode = 2'd2;
      w_best_sad  = w_cost_dc;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the neighbour arrays are only 2 x 16 bytes of flops, so they are
  // cleared by reset like every other register; a true RAM would not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        r_top[k]  <= '0;
        r_left[k] <= '0;
      end
      r_top_avail  <= 1'b0;
      r_left_avail <= 1'b0;
      r_row        <= '0;
      r_dc_pred    <= '0;
      r_acc_v      <= '0;
      r_acc_h      <= '0;
      r_acc_dc     <= '0;
      r_best_mode  <= '0;
      r_best_sad   <= '0;
      r_sad_v      <= '0;
      r_sad_h      <= '0;
      r_sad_dc     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          for (int k = 0; k < 16; k++) begin
            r_top[k]  <= bus.top[k];
            r_left[k] <= bus.left[k];
          end
          r_top_avail  <= bus.top_avail;
          r_left_avail <= bus.left_avail;
          r_row        <= '0;
          r_acc_v      <= '0;
          r_acc_h      <= '0;
          r_acc_dc     <= '0;
        end
        S_DCCALC: r_dc_pred <= w_dc_pred;
        S_ACCUM: begin
          // 16 rows x 16 px x 255 = 65280 max, so 16 bits never wrap.
          r_acc_v  <= r_acc_v  + 16'(w_row_v);
          r_acc_h  <= r_acc_h  + 16'(w_row_h);
          r_acc_dc <= r_acc_dc + 16'(w_row_dc);
          r_row    <= r_row + 4'd1;
        end
        S_DECIDE: begin
          r_best_mode <= w_best_mode;
          r_best_sad  <= w_best_sad;
          r_sad_v     <= w_raw_v;
          r_sad_h     <= w_raw_h;
          r_sad_dc    <= r_acc_dc;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.best_mode = r_best_mode;
  assign bus.best_sad  = r_best_sad;
  assign bus.sad_v     = r_sad_v;
  assign bus.sad_h     = r_sad_h;
  assign bus.sad_dc    = r_sad_dc;

endmodule

// File: tb/tb_intra16_mode_decision.sv
// ---------------------------------------------------------------------------
// tb_intra16_mode_decision
//   Directed self-checking bench for intra16_mode_decision. Each scenario task
//   drives one macroblock and compares the result against hand-computed
//   values. Cycle 0 is the cycle in which start is sampled high.
// ---------------------------------------------------------------------------
module tb_intra16_mode_decision;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  intra16_mode_decision_if bus ();

  intra16_mode_decision #(.MB_SIZE(16), .MODE_BIAS(50)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- stimulus helpers ----------------
  task automatic fill_mb_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) bus.mb[i] = v;
  endtask

  task automatic fill_mb_row_ramp();
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++) bus.mb[j*16+k] = 8'(10*j);
  endtask

  task automatic set_top(input logic [7:0] v);
    for (int k = 0; k < 16; k++) bus.top[k] = v;
  endtask

  task automatic set_left(input logic [7:0] v);
    for (int k = 0; k < 16; k++) bus.left[k] = v;
  endtask

  // Pulses start and returns the cycle in which out_valid is first seen
  // high (40 means it never rose within the budget).
  task automatic run_mb(output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 40) $display("FAIL timeout: out_valid never rose within 40 cycles");
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    checks++; if ({bus.best_mode, bus.best_sad, bus.sad_v, bus.sad_h, bus.sad_dc} !== 66'd0) begin
      errors++; $display("FAIL reset_results got mode %0d best %0d v %0d h %0d dc %0d want all 0",
                         bus.best_mode, bus.best_sad, bus.sad_v, bus.sad_h, bus.sad_dc);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_flat(input string tag);
    int lat;
    fill_mb_const(8'd100); set_top(8'd100); set_left(8'd100);
    bus.top_avail = 1'b1; bus.left_avail = 1'b1;
    run_mb(lat);
    checks++; if (lat !== 19) begin errors++; $display("FAIL %s_latency got %0d want 19", tag, lat); end
    checks++; if (bus.sad_v !== 16'd0 || bus.sad_h !== 16'd0 || bus.sad_dc !== 16'd0) begin
      errors++; $display("FAIL %s_sads got v %0d h %0d dc %0d want 0 0 0", tag, bus.sad_v, bus.sad_h, bus.sad_dc);
    end
    checks++; if (bus.best_mode !== 2'd0 || bus.best_sad !== 16'd0) begin
      errors++; $display("FAIL %s_best got mode %0d sad %0d want 0 0", tag, bus.best_mode, bus.best_sad);
    end
    release_result();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_idle got busy %0b valid %0b want 0 0", tag, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_horizontal();
    int lat;
    fill_mb_row_ramp(); set_top(8'd50);
    for (int j = 0; j < 16; j++) bus.left[j] = 8'(10*j);
    bus.top_avail = 1'b1; bus.left_avail = 1'b1;
    run_mb(lat);
    // dc_pred = (800 + 1200 + 16) >> 5 = 63; sad_dc = 16 * 654 = 10464
    checks++; if (bus.sad_v !== 16'd11200) begin errors++; $display("FAIL horiz_sad_v got %0d want 11200", bus.sad_v); end
    checks++; if (bus.sad_h !== 16'd0) begin errors++; $display("FAIL horiz_sad_h got %0d want 0", bus.sad_h); end
    checks++; if (bus.sad_dc !== 16'd10464) begin errors++; $display("FAIL horiz_sad_dc got %0d want 10464", bus.sad_dc); end
    checks++; if (bus.best_mode !== 2'd1 || bus.best_sad !== 16'd0) begin
      errors++; $display("FAIL horiz_best got mode %0d sad %0d want 1 0", bus.best_mode, bus.best_sad);
    end
    release_result();
  endtask

  task automatic test_no_neighbours();
    int lat;
    fill_mb_const(8'd128); set_top(8'd7); set_left(8'd250);
    bus.top_avail = 1'b0; bus.left_avail = 1'b0;
    run_mb(lat);
    checks++; if (bus.sad_v !== 16'hFFFF || bus.sad_h !== 16'hFFFF) begin
      errors++; $display("FAIL nonb_forced got v %0h h %0h want ffff ffff", bus.sad_v, bus.sad_h);
    end
    checks++; if (bus.sad_dc !== 16'd0) begin errors++; $display("FAIL nonb_sad_dc got %0d want 0", bus.sad_dc); end
    checks++; if (bus.best_mode !== 2'd2 || bus.best_sad !== 16'd0) begin
      errors++; $display("FAIL nonb_best got mode %0d sad %0d want 2 0", bus.best_mode, bus.best_sad);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    fill_mb_const(8'd200); set_top(8'd200); set_left(8'd3);
    bus.top_avail = 1'b1; bus.left_avail = 1'b0;
    run_mb(lat);
    checks++; if (lat !== 19) begin errors++; $display("FAIL bp_latency got %0d want 19", lat); end
    // dc_pred = (3200 + 8) >> 4 = 200 -> sad_dc 0, tie V/DC resolves to V.
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.best_mode !== 2'd0 || bus.best_sad !== 16'd0 ||
          bus.sad_v !== 16'd0 || bus.sad_h !== 16'hFFFF || bus.sad_dc !== 16'd0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid %0b mode %0d best %0d v %0d h %0h dc %0d want 1 0 0 0 ffff 0",
                 c, bus.out_valid, bus.best_mode, bus.best_sad, bus.sad_v, bus.sad_h, bus.sad_dc);
      end
    end
    release_result();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle got busy %0b valid %0b want 0 0", bus.busy, bus.out_valid);
    end
    // The start pulsed during DONE must not have been queued.
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored got busy %0b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    bit saw_valid;
    fill_mb_const(8'd100); set_top(8'd100); set_left(8'd100);
    bus.top_avail = 1'b1; bus.left_avail = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);   // now in cycle 10 = ACCUM row 8
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got busy %0b valid %0b want 0 0", bus.busy, bus.out_valid);
    end
    checks++; if ({bus.best_mode, bus.best_sad, bus.sad_v, bus.sad_h, bus.sad_dc} !== 66'd0) begin
      errors++; $display("FAIL rst_mid_results got mode %0d best %0d v %0d h %0d dc %0d want all 0",
                         bus.best_mode, bus.best_sad, bus.sad_v, bus.sad_h, bus.sad_dc);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_partial got out_valid 1 want 0"); end
    test_flat("rst_flat");
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    bus.out_ready = 1'b1;
    fill_mb_row_ramp(); set_top(8'd50);
    for (int j = 0; j < 16; j++) bus.left[j] = 8'(10*j);
    bus.top_avail = 1'b1; bus.left_avail = 1'b1;
    run_mb(lat1);
    checks++; if (lat1 !== 19 || bus.best_mode !== 2'd1) begin
      errors++; $display("FAIL b2b_first got lat %0d mode %0d want 19 1", lat1, bus.best_mode);
    end
    fill_mb_const(8'd128);
    bus.top_avail = 1'b0; bus.left_avail = 1'b0;
    run_mb(lat2);   // start lands in cycle 20 of the first MB
    checks++; if (lat2 !== 19 || bus.best_mode !== 2'd2 || bus.sad_dc !== 16'd0) begin
      errors++; $display("FAIL b2b_second got lat %0d mode %0d dc %0d want 19 2 0", lat2, bus.best_mode, bus.sad_dc);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %0b want 0", bus.busy); end
  endtask

  task automatic test_bias();
    int lat;
    fill_mb_const(8'd100); set_top(8'd100); set_left(8'd90);
    bus.top_avail = 1'b1; bus.left_avail = 1'b1;
    run_mb(lat);
    // dc_pred = (1600 + 1440 + 16) >> 5 = 95
    checks++; if (bus.sad_v !== 16'd0 || bus.sad_h !== 16'd2560 || bus.sad_dc !== 16'd1280) begin
      errors++; $display("FAIL bias_raw got v %0d h %0d dc %0d want 0 2560 1280", bus.sad_v, bus.sad_h, bus.sad_dc);
    end
`ifdef INTRA16_MODE_BIAS_EN
    checks++; if (bus.best_mode !== 2'd0 || bus.best_sad !== 16'd50) begin
      errors++; $display("FAIL bias_best got mode %0d sad %0d want 0 50", bus.best_mode, bus.best_sad);
    end
`else
    checks++; if (bus.best_mode !== 2'd0 || bus.best_sad !== 16'd0) begin
      errors++; $display("FAIL bias_best got mode %0d sad %0d want 0 0", bus.best_mode, bus.best_sad);
    end
`endif
    release_result();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.top_avail  = 1'b0;
    bus.left_avail = 1'b0;
    fill_mb_const(8'd0); set_top(8'd0); set_left(8'd0);

    test_reset();
    test_flat("flat");
    test_horizontal();
    test_no_neighbours();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_bias();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intra16_mode_decision.md
Name: intra16_mode_decision

Overview:
- Downstream of the macroblock extractor in the IntraPred path.
- Consumes one 16x16 luma macroblock plus its reconstructed top-row and left-column neighbours.
- Evaluates the Intra16x16 vertical, horizontal and DC predictions by SAD, one MB row per cycle.
- Reports the cheapest mode and all three SADs to the encoder control through a valid/ready output handshake.

Parameters:
- MB_SIZE, 16, macroblock edge in pixels; only 16 is supported.
- MODE_BIAS, 0, 16-bit cost added to the V and H SADs before comparison; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; accepted only in IDLE
- mb  in  8 x 256 (unpacked array [7:0] mb [255:0])  pixel (row j, col k) at index j*16+k; must stay stable from the start cycle until out_valid
- top  in  8 x 16  neighbour row above the MB, index = column
- left  in  8 x 16  neighbour column left of the MB, index = row
- top_avail  in  1  top neighbours valid
- left_avail  in  1  left neighbours valid
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- best_mode  out  2  0 = vertical, 1 = horizontal, 2 = DC
- best_sad  out  16  SAD of best_mode, bias included
- sad_v  out  16  raw vertical SAD
- sad_h  out  16  raw horizontal SAD
- sad_dc  out  16  raw DC SAD

Behaviour:
- Reset: state IDLE; all outputs 0; accumulators, latched neighbours and row counter cleared.
- Reset mid-operation aborts the current MB; no partial result is emitted.
- FSM: IDLE -> DCCALC -> ACCUM -> DECIDE -> DONE -> IDLE.
- IDLE: on start, latch top, left, top_avail and left_avail; clear the accumulators and the row counter; go to DCCALC.
- DCCALC (1 cycle): compute sumT and sumL as 12-bit sums, then dc_pred:
  - both available: (sumT+sumL+16)>>5
  - top only: (sumT+8)>>4
  - left only: (sumL+8)>>4
  - neither: 128
- ACCUM (16 cycles, row r = 0..15): for each k = 0..15, accumulate
  - sad_v += |mb[r*16+k] - top[k]|
  - sad_h += |mb[r*16+k] - left[r]|
  - sad_dc += |mb[r*16+k] - dc_pred|
  - Accumulators are 16-bit; the maximum is 65280, so no overflow is possible.
  - Exit to DECIDE after r = 15.
- DECIDE (1 cycle):
  - sad_v is forced to 16'hFFFF if !top_avail; sad_h is forced to 16'hFFFF if !left_avail. DC is always a candidate.
  - Select the minimum cost. Ties resolve to the lower mode number.
- DONE: out_valid = 1; all result outputs are held stable until the cycle where out_ready = 1, then go to IDLE with out_valid = 0 on the next cycle.
- Latency: start accepted at cycle 0 -> out_valid first high at cycle 19. Back-to-back throughput is one MB per 20 cycles with out_ready tied high.
- start while busy is ignored and not queued.
- out_ready outside DONE has no effect.

Optional Feature:
- Macro: INTRA16_MODE_BIAS_EN.
- Defined: MODE_BIAS is added to the V and H costs in DECIDE, saturating at 16'hFFFF; best_sad reports the biased cost. The forced-unavailable value stays 16'hFFFF.
- Undefined: no bias; best_sad equals the raw SAD of the chosen mode. MODE_BIAS is ignored.
- sad_v, sad_h and sad_dc are always raw, with or without the macro.

Test Plan:
- Flat case: mb, top and left all 100, both available, start at cycle 0 -> out_valid at cycle 19; all SADs 0; best_mode 0 (tie to lowest mode); best_sad 0.
- Horizontal case: mb row j = 10*j, left[j] = 10*j, top all 50, both available -> sad_h 0, sad_v 11200; best_mode 1, best_sad 0.
- No neighbours: mb all 128, neither available -> sad_dc 0, sad_v = sad_h = 16'hFFFF; best_mode 2.
- Backpressure: top-only case, mb all 200, top all 200, out_ready low for 5 cycles, start pulsed during DONE -> dc_pred 200, best_mode 0; outputs stable while stalled; extra start ignored; IDLE one cycle after out_ready.
- Reset mid-run: assert reset during ACCUM row 8 -> busy 0 and all outputs 0 immediately; next start yields a correct flat-case result at cycle 19.
- Bias (macro on, MODE_BIAS 50): mb all 100, top all 100, left all 90, both available -> sad_v 0, sad_h 2560, sad_dc 1280 (dc_pred 95); costs 50 / 2610 / 1280; best_mode 0, best_sad 50.
